// File: rtl/ahb3lite_burst_gen.sv
// ahb3lite_burst_gen: AHB3-Lite master that expands one command into a SINGLE/INCR/WRAP burst.
module ahb3lite_burst_gen (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [2:0]  cmd_burst,
  input  logic [4:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic        cmd_write,
  input  logic        wdata_valid,
  input  logic [31:0] wdata,
  output logic        wdata_ready,
  input  logic        HREADY,
  output logic [31:0] i_HADDR,
  output logic [31:0] i_HWDATA,
  output logic        i_HWRITE,
  output logic [1:0]  i_HTRANS,
  output logic [2:0]  i_HSIZE,
  output logic [2:0]  i_HBURST,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, ADDR, LAST_DATA} state_t;
  localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NONSEQ = 2'd2, T_SEQ = 2'd3;
  state_t state, state_nxt;
  logic [4:0] rem, beats;
  logic [31:0] wbuf, inc, wmask, addr_nxt;
  logic accept, beat_done, busy_done, take, wrap;
  always_comb begin
    beats = cmd_burst == 3'd0 ? 5'd1 : cmd_burst == 3'd1 ? (cmd_len == 5'd0 ? 5'd1 : cmd_len) : 5'd2 << cmd_burst[2:1];
    inc = 32'd1 << i_HSIZE;
    wrap = ~i_HBURST[0] & (i_HBURST != 3'd0);
    wmask = (inc << ({1'b0, i_HBURST[2:1]} + 3'd1)) - 32'd1;
    addr_nxt = wrap ? (i_HADDR & ~wmask) | ((i_HADDR + inc) & wmask) : i_HADDR + inc;
    cmd_ready = state == IDLE & ~HRESET & (~cmd_write | wdata_valid);
    accept = cmd_valid & cmd_ready;
    beat_done = state == ADDR & HREADY & i_HTRANS[1];
    busy_done = state == ADDR & HREADY & i_HTRANS == T_BUSY;
    // rem counts beats still to follow the one currently on the address bus
    wdata_ready = ~HRESET & ((state == IDLE & cmd_valid & cmd_write) |
                  (state == ADDR & HREADY & i_HWRITE & ((i_HTRANS[1] & rem != 5'd0) | i_HTRANS == T_BUSY)));
    take = wdata_valid & wdata_ready;
    done = state == LAST_DATA & HREADY & ~HRESET;
    busy = state != IDLE;
    state_nxt = state == IDLE ? (accept ? ADDR : IDLE) :
                state == ADDR ? (beat_done & rem == 5'd0 ? LAST_DATA : ADDR) :
                (HREADY ? IDLE : LAST_DATA);
  end
  always_ff @(posedge HCLK) state <= HRESET ? IDLE : state_nxt;
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      i_HADDR <= '0;
      i_HWDATA <= '0;
      i_HWRITE <= 1'b0;
      i_HTRANS <= T_IDLE;
      i_HSIZE <= '0;
      i_HBURST <= '0;
      rem <= '0;
      wbuf <= '0;
    end else begin
      if (accept) begin
        i_HADDR <= cmd_addr;
        i_HTRANS <= T_NONSEQ;
        i_HWRITE <= cmd_write;
        i_HSIZE <= cmd_size > 3'd2 ? 3'd2 : cmd_size;
        i_HBURST <= cmd_burst;
        rem <= beats - 5'd1;
      end else if (beat_done) begin
        i_HWDATA <= wbuf;
        if (rem == 5'd0) i_HTRANS <= T_IDLE;
        else begin
          i_HADDR <= addr_nxt;
          rem <= rem - 5'd1;
          i_HTRANS <= i_HWRITE & ~wdata_valid ? T_BUSY : T_SEQ;
        end
      end else if (busy_done & wdata_valid) i_HTRANS <= T_SEQ;
      if (take) wbuf <= wdata;
    end
  end
endmodule

// File: tb/tb_ahb3lite_burst_gen.sv
// tb_ahb3lite_burst_gen: directed and random bursts checked against an address/data list model.
module tb_ahb3lite_burst_gen;
  logic HCLK = 1'b0, HRESET, cmd_valid, cmd_ready, cmd_write, wdata_valid, wdata_ready, HREADY;
  logic [31:0] cmd_addr, wdata, i_HADDR, i_HWDATA;
  logic [2:0] cmd_burst, cmd_size, i_HSIZE, i_HBURST;
  logic [4:0] cmd_len;
  logic i_HWRITE, busy, done;
  logic [1:0] i_HTRANS;
  int n_cmp = 0, n_err = 0, lat, nb;
  always #5 HCLK = ~HCLK;
  ahb3lite_burst_gen dut (.HCLK(HCLK), .HRESET(HRESET), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_len(cmd_len), .cmd_size(cmd_size),
    .cmd_write(cmd_write), .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .HREADY(HREADY), .i_HADDR(i_HADDR), .i_HWDATA(i_HWDATA), .i_HWRITE(i_HWRITE),
    .i_HTRANS(i_HTRANS), .i_HSIZE(i_HSIZE), .i_HBURST(i_HBURST), .busy(busy), .done(done));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic [2:0] burst, input logic [4:0] len, input logic [2:0] size,
                     input logic wr, input logic [31:0] addr, input int p_hlow, input int p_wlow,
                     input int h0, input int hn, input int wb, input int wn, output int lt, output int nbs);
    int tbl [8] = '{1, 0, 4, 4, 8, 8, 16, 16};
    logic [31:0] ea [16];
    logic [31:0] ed [16];
    logic [31:0] inc, b32, base, sz;
    int n, a_idx, d_idx, w_idx, wcnt;
    bit fin, hr, ewr, edn;
    logic [1:0] etr;
    n = burst == 3'd1 ? (len == 5'd0 ? 1 : int'(len)) : tbl[burst];
    sz = size > 3'd2 ? 32'd2 : 32'(size);
    inc = 32'd1 << sz;
    b32 = 32'(n) * inc;
    base = addr - addr % b32;
    for (int k = 0; k < n; k++) begin
      ea[k] = (burst inside {3'd2, 3'd4, 3'd6}) ? base + (addr - base + 32'(k) * inc) % b32 : addr + 32'(k) * inc;
      ed[k] = $urandom;
    end
    @(negedge HCLK);
    cmd_valid = 1'b1; cmd_addr = addr; cmd_burst = burst; cmd_len = len; cmd_size = size; cmd_write = wr;
    wdata_valid = wr ? 1'b1 : 1'($urandom); wdata = ed[0];
    HREADY = $urandom_range(0, 99) >= p_hlow;
    #1;
    chk("idle_busy", busy, 0);
    chk("cmd_ready", cmd_ready, 1);
    chk("accept_wready", wdata_ready, 32'(wr));
    a_idx = 0; d_idx = -1; w_idx = wr ? 1 : 0; wcnt = wn; fin = 0; lt = 0; nbs = 0;
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge HCLK);
      cmd_valid = 1'($urandom); cmd_addr = $urandom; cmd_burst = 3'($urandom);
      cmd_len = 5'($urandom); cmd_size = 3'($urandom); cmd_write = 1'($urandom);
      hr = (cyc >= h0 && cyc < h0 + hn) ? 1'b0 : ($urandom_range(0, 99) >= p_hlow);
      HREADY = hr;
      if (wr && w_idx == wb && wcnt > 0) begin
        wdata_valid = 1'b0;
        wcnt--;
      end else wdata_valid = wr ? ($urandom_range(0, 99) >= p_wlow) : 1'($urandom);
      wdata = w_idx < n ? ed[w_idx] : $urandom;
      #1;
      etr = a_idx >= n ? 2'd0 : a_idx == 0 ? 2'd2 : (wr && w_idx <= a_idx) ? 2'd1 : 2'd3;
      edn = d_idx == n - 1 && hr;
      ewr = wr && hr && a_idx < n && w_idx < n;
      chk("busy", busy, 1);
      chk("cmd_ready_held", cmd_ready, 0);
      chk("done", done, 32'(edn));
      chk("wdata_ready", wdata_ready, 32'(ewr));
      chk("htrans", i_HTRANS, 32'(etr));
      if (a_idx < n) chk("haddr", i_HADDR, ea[a_idx]);
      chk("hwrite", i_HWRITE, 32'(wr));
      chk("hsize", i_HSIZE, sz);
      chk("hburst", i_HBURST, 32'(burst));
      if (wr && d_idx >= 0) chk("hwdata", i_HWDATA, ed[d_idx]);
      if (etr == 2'd1) nbs++;
      if (edn) begin
        fin = 1;
        lt = cyc + 1;
      end
      if (hr) begin
        d_idx = -1;
        if (etr[1]) begin
          d_idx = a_idx;
          a_idx++;
        end
      end
      if (ewr && wdata_valid) w_idx++;
    end
    chk("finished", 32'(fin), 1);
    cmd_valid = 1'b0;
  endtask
  initial begin
    HRESET = 1; cmd_valid = 1; cmd_write = 1; wdata_valid = 1; HREADY = 1;
    cmd_addr = 32'h1234; cmd_burst = 3'd3; cmd_len = 0; cmd_size = 3'd2; wdata = 32'hdead;
    repeat (3) @(negedge HCLK);
    #1;
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_wready", wdata_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_htrans", i_HTRANS, 0);
    chk("rst_haddr", i_HADDR, 0);
    chk("rst_hwdata", i_HWDATA, 0);
    chk("rst_hwrite", i_HWRITE, 0);
    chk("rst_hsize", i_HSIZE, 0);
    chk("rst_hburst", i_HBURST, 0);
    @(negedge HCLK);
    HRESET = 0; cmd_valid = 0;
    run(3'd3, 5'd0, 3'd2, 1'b0, 32'h100, 0, 0, 0, 0, -1, 0, lat, nb);
    chk("lat_incr4", lat, 5);
    run(3'd2, 5'd0, 3'd2, 1'b1, 32'h38, 0, 0, 0, 0, -1, 0, lat, nb);
    run(3'd5, 5'd0, 3'd2, 1'b1, 32'h1000, 0, 0, 0, 0, 3, 2, lat, nb);
    chk("busy_cycles", nb, 2);
    run(3'd3, 5'd0, 3'd2, 1'b0, 32'h100, 0, 0, 1, 3, -1, 0, lat, nb);
    chk("lat_hready_stall", lat, 8);
    run(3'd1, 5'd3, 3'd2, 1'b0, 32'hFFFF_FFFC, 0, 0, 0, 0, -1, 0, lat, nb);
    run(3'd1, 5'd3, 3'd2, 1'b1, 32'hFFFF_FFFC, 0, 0, 0, 0, -1, 0, lat, nb);
    run(3'd0, 5'd9, 3'd7, 1'b1, 32'h40, 0, 0, 0, 0, -1, 0, lat, nb);
    chk("lat_single", lat, 2);
    run(3'd6, 5'd0, 3'd1, 1'b1, 32'h7A, 20, 30, 0, 0, -1, 0, lat, nb);
    @(negedge HCLK);
    cmd_valid = 1; cmd_addr = 32'h2000; cmd_burst = 3'd7; cmd_len = 0; cmd_size = 3'd2; cmd_write = 0; HREADY = 1;
    @(negedge HCLK);
    cmd_valid = 0;
    @(negedge HCLK);
    @(negedge HCLK);
    #1;
    chk("pre_rst_htrans", i_HTRANS, 3);
    chk("pre_rst_haddr", i_HADDR, 32'h2008);
    HRESET = 1;
    #1;
    chk("in_rst_done", done, 0);
    chk("in_rst_cmd_ready", cmd_ready, 0);
    @(negedge HCLK);
    #1;
    chk("abort_htrans", i_HTRANS, 0);
    chk("abort_haddr", i_HADDR, 0);
    chk("abort_hwdata", i_HWDATA, 0);
    chk("abort_hwrite", i_HWRITE, 0);
    chk("abort_hsize", i_HSIZE, 0);
    chk("abort_hburst", i_HBURST, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge HCLK);
    HRESET = 0;
    repeat (5) begin
      #1;
      chk("post_done", done, 0);
      chk("post_htrans", i_HTRANS, 0);
      chk("post_busy", busy, 0);
      @(negedge HCLK);
    end
    for (int i = 0; i < 40; i++) begin
      logic [2:0] b, s;
      logic [31:0] a;
      b = 3'($urandom);
      s = 3'($urandom);
      a = $urandom & ~((32'd1 << (s > 3'd2 ? 2 : s)) - 32'd1);
      run(b, 5'($urandom_range(0, 16)), s, 1'($urandom), a, 30, 30, 0, 0, -1, 0, lat, nb);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
